// File: rtl/booth_mul_8bit_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding, iteration count and the sign-recovery helper.
package booth_mul_8bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BOOTH_ITER = 8;
  localparam logic [2:0] LAST_COUNT = 3'(BOOTH_ITER - 1);

  // Sign bit of the 9-bit partial sum. When an add/sub was taken the 8-bit
  // result may have overflowed (e.g. 0 - (-128)); S[7]^ov recovers the true
  // sign. Otherwise the accumulator passes through and keeps its own sign.
  function automatic logic true_sign(input logic taken, input logic s7,
                                     input logic ov, input logic acc7);
    return taken ? (s7 ^ ov) : acc7;
  endfunction

endpackage

// File: rtl/booth_mul_8bit_addsub.sv
// 8-bit two's-complement add/subtract unit: S = A + B (addsub=0) or
// S = A - B (addsub=1), with carry-out and signed overflow flag.
module addsub_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       addsub,
  output logic [7:0] S,
  output logic       cout,
  output logic       ov_flag
);

  logic [7:0] w_bx;

  assign w_bx = B ^ {8{addsub}};

  // Single ripple sum; subtraction is add of the inverted operand plus one.
  always_comb begin
    {cout, S} = {1'b0, A} + {1'b0, w_bx} + {8'd0, addsub};
    ov_flag   = (A[7] == w_bx[7]) && (S[7] != A[7]);
  end

endmodule

// File: rtl/booth_mul_8bit.sv
// Sequential signed 8x8 radix-2 Booth multiplier. One partial-product step
// per clock through a single addsub_8bit; start/done handshake, 16-bit
// product held until the next completion.
module booth_mul_8bit
  import booth_mul_8bit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] P
);

  state_t             r_state;
  logic signed [7:0]  r_acc;
  logic        [7:0]  r_q;
  logic               r_q1;
  logic signed [7:0]  r_m;
  logic        [2:0]  r_count;
  logic               r_busy;
  logic               r_done;
  logic        [15:0] r_p;

  logic [7:0] w_s;
  logic       w_cout;
  logic       w_ov;
  logic       w_addsub;
  logic       w_take;
  logic [7:0] w_sum;
  logic       w_ts;
  logic [7:0] w_acc_next;
  logic [7:0] w_q_next;
  logic       w_unused;

  // Booth recoding of {Q[0], q_1}: 10 subtracts M, 01 adds M.
  assign w_addsub = r_q[0] & ~r_q1;
  assign w_take   = r_q[0] ^ r_q1;

  addsub_8bit u_addsub (
    .A       (r_acc),
    .B       (r_m),
    .addsub  (w_addsub),
    .S       (w_s),
    .cout    (w_cout),
    .ov_flag (w_ov)
  );

  // Carry-out has no role in a signed Booth step.
  assign w_unused = w_cout;

  // Partial sum and its arithmetic right shift across {ACC, Q}.
  always_comb begin
    w_sum      = w_take ? w_s : r_acc;
    w_ts       = true_sign(w_take, w_s[7], w_ov, r_acc[7]);
    w_acc_next = {w_ts, w_sum[7:1]};
    w_q_next   = {w_sum[0], r_q[7:1]};
  end

  // Control FSM with registered busy/done and the shift datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= A;
            r_q     <= B;
            r_acc   <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_q     <= w_q_next;
          r_q1    <= r_q[0];
          r_count <= r_count + 3'd1;
          if (r_count == LAST_COUNT) begin
            r_p     <= {w_acc_next, w_q_next};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;

endmodule

// File: tb/tb_booth_mul_8bit.sv
// Directed and reference-model bench for booth_mul_8bit.
module tb_booth_mul_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] P;

  int checks;
  int errors;

  booth_mul_8bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one multiply and wait (bounded) for done. Reports the product,
  // edges from acceptance to done, busy-high cycles and whether P moved
  // before done.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] p, output int lat,
                         output int bcnt, output bit moved);
    logic [15:0] p0;
    p0 = P;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; moved = 1'b0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (busy) bcnt++;
      if (!done && P !== p0) moved = 1'b1;
    end
    p = P;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || P !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b P=%h required 0 0 0000", busy, done, P);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat; int bcnt; bit moved;
    run_mul(8'd2, 8'd1, p, lat, bcnt, moved);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d required 8", lat); end
    checks++;
    if (p !== 16'h0002) begin errors++; $display("FAIL basic_product got %h required 0002", p); end
    checks++;
    if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d required 8", bcnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b required 0", busy); end
    tick();
    checks++;
    if (done !== 1'b0 || P !== 16'h0002) begin
      errors++;
      $display("FAIL basic_done_width done=%b P=%h required 0 0002", done, P);
    end
  endtask

  task automatic test_directed();
    logic [7:0]  va [4] = '{8'd7,  8'h80, 8'h80, 8'h00};
    logic [7:0]  vb [4] = '{8'hFB, 8'h80, 8'h7F, 8'hFF};
    logic [15:0] ve [4] = '{16'hFFDD, 16'h4000, 16'hC080, 16'h0000};
    logic [15:0] p; int lat; int bcnt; bit moved;
    for (int i = 0; i < 4; i++) begin
      run_mul(va[i], vb[i], p, lat, bcnt, moved);
      checks++;
      if (p !== ve[i] || lat !== 8) begin
        errors++;
        $display("FAIL directed_%0d A=%h B=%h got P=%h lat=%0d required P=%h lat=8",
                 i, va[i], vb[i], p, lat, ve[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_during_run();
    int n; int ndone;
    A = 8'd9; B = 8'hFD; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; A = 8'd100; B = 8'd100;
    n = 2;
    while (!done && n < 30) begin
      tick();
      n++;
      start = 1'b0;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL ignore_start_latency got %0d required 8", n); end
    checks++;
    if (P !== 16'hFFE5) begin errors++; $display("FAIL ignore_start_product got %h required FFE5", P); end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL ignore_start_extra_done got %0d required 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int n;
    A = 8'd3; B = 8'd4; start = 1'b1;
    tick();
    A = 8'd5; B = 8'hFE;
    n = 0;
    while (!done && n < 30) begin tick(); n++; end
    checks++;
    if (n !== 8 || P !== 16'h000C) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d P=%h required lat=8 P=000C", n, P);
    end
    n = 0;
    do begin tick(); n++; end while (!done && n < 30);
    start = 1'b0;
    checks++;
    if (n !== 9 || P !== 16'hFFF6) begin
      errors++;
      $display("FAIL b2b_second got gap=%0d P=%h required gap=9 P=FFF6", n, P);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; int lat; int bcnt; bit moved; int ndone;
    A = 8'd5; B = 8'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || P !== 16'h0000) begin
      errors++;
      $display("FAIL midrun_reset busy=%b done=%b P=%h required 0 0 0000", busy, done, P);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL midrun_reset_activity got %0d required 0", ndone); end
    run_mul(8'd5, 8'd6, p, lat, bcnt, moved);
    checks++;
    if (p !== 16'h001E || lat !== 8) begin
      errors++;
      $display("FAIL after_reset_product got P=%h lat=%0d required 001E lat=8", p, lat);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  sp [5] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};
    logic [7:0]  a; logic [7:0] b;
    logic [15:0] p; logic [15:0] ref_p; logic [15:0] prev;
    int lat; int bcnt; bit moved;
    for (int k = 0; k < 256; k++) begin
      if (k < 25) begin
        a = sp[k / 5]; b = sp[k % 5];
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      end
      ref_p = 16'(int'($signed(a)) * int'($signed(b)));
      prev = P;
      run_mul(a, b, p, lat, bcnt, moved);
      checks++;
      if (p !== ref_p || lat !== 8) begin
        errors++;
        $display("FAIL rand_%0d A=%h B=%h got P=%h lat=%0d required P=%h lat=8",
                 k, a, b, p, lat, ref_p);
      end
      checks++;
      if (moved) begin
        errors++;
        $display("FAIL rand_stable_%0d P changed before done, held value %h", k, prev);
      end
      tick();
      checks++;
      if (done !== 1'b0 || P !== ref_p) begin
        errors++;
        $display("FAIL rand_pulse_%0d done=%b P=%h required 0 %h", k, done, P, ref_p);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    test_reset();
    test_basic();
    test_directed();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
